fifo_mem_control: RTL and testbench
===================================

# fifo_mem_control

Sequencing controller for the dual-port FIFO storage memory (10-bit words, 256 entries by default). It turns requester push/pop requests into the memory's `wrmem_enable`/`rdmem_enable` strobes and write/read addresses. It tracks occupancy and raises empty, full, almost-empty and almost-full flags. It latches overflow and underflow as a sticky error. It sits between the upstream/downstream flow-control logic and the memory instance; data words pass directly to the memory and do not go through this block.

## Interface
- `data_width`, 10, memory word width; pass-through only, for consistency with the memory instance.
- `address_width`, 8, memory address width; depth D = 2^address_width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `init`  in  1  synchronous re-initialisation; also clears the error.
- `push`  in  1  requester write request.
- `pop`  in  1  requester read request.
- `thr_high`  in  address_width+1  almost-full threshold; sampled in INIT.
- `thr_low`  in  address_width+1  almost-empty threshold; sampled in INIT.
- `wrmem_enable`  out  1  memory write strobe.
- `rdmem_enable`  out  1  memory read strobe.
- `wr_addr`  out  address_width  memory write address.
- `rd_addr`  out  address_width  memory read address.
- `valid_out`  out  1  memory read data valid; registered.
- `count`  out  address_width+1  occupancy, range 0..D.
- `empty`, `full`, `almost_empty`, `almost_full`  out  1 each  status flags.
- `error`  out  1  sticky overflow/underflow flag.
- `state`  out  2  current FSM state, for debug.

## Operation
- FSM states: INIT=0, IDLE=1, ACTIVE=2, ERROR=3.
  - INIT: pointers and count cleared; thresholds captured into internal registers. Go to IDLE when `init`=0.
  - IDLE: count=0. Go to ACTIVE on an accepted push.
  - ACTIVE: count>0. Go to IDLE when count reaches 0.
  - ERROR: no push or pop is accepted. Leave only when `init`=1 (go to INIT).
  - From any state, `init`=1 forces INIT on the next edge.
- Accept rules, evaluated only in IDLE and ACTIVE:
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - push while full → overflow, even if pop is asserted in the same cycle; the pop is still accepted that cycle.
  - pop while empty → underflow; there is no bypass, even if push is asserted in the same cycle.
  - Overflow or underflow sets `error`=1 and moves the FSM to ERROR on the next edge.
- `wrmem_enable` = push_ok and `rdmem_enable` = pop_ok, both combinational in the same cycle.
- `wr_addr` = wr_ptr and `rd_addr` = rd_ptr, both registered.
- Pointers increment modulo D; natural wrap from D-1 to 0.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Flags are pure decodes of the registered count and the captured thresholds:
  - empty = (count==0)
  - full = (count==D)
  - almost_empty = (count<=thr_low_q)
  - almost_full = (count>=thr_high_q)
- `valid_out` = pop_ok delayed by one cycle.

## Timing
- Reset values:
  - state = INIT
  - wr_ptr = rd_ptr = 0, count = 0
  - thr_low_q = 0, thr_high_q = D
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - error = 0, valid_out = 0
  - wrmem_enable = rdmem_enable = 0
- Asserting `reset` mid-operation clears everything immediately. Memory contents are not cleared.
- Write latency: data presented with push_ok is stored at the same edge.
- Read latency: memory read data and `valid_out` appear one cycle after the pop_ok cycle.
- Flags and count reflect a push or pop from the following cycle onward.
- Threshold changes outside INIT are ignored.

## Structure
- Shared package holds the FSM state encodings (INIT, IDLE, ACTIVE, ERROR).
- Shared package also holds the default `data_width` and `address_width`, so the memory, this controller and the benches agree.
- Natural sub-module: `fifo_ptr`, a wrapping pointer counter with enable, instantiated twice (write and read).
- Flag decode and FSM stay in the top module.

## Test plan
- Reset with `init`=1 for 2 cycles, then `init`=0 → state INIT then IDLE; empty=1, almost_empty=1, count=0, all strobes 0.
- `thr_low`=2 and `thr_high`=254 sampled in INIT; 3 pushes → wr_addr 0,1,2 with wrmem_enable=1; count=3; almost_empty drops after the 3rd push; state ACTIVE.
- Fill to 256 → full=1 and almost_full=1 (almost_full from count 254); wr_addr wraps to 0. A further push → error=1 and state ERROR next cycle; wrmem_enable stays 0.
- From count=5: push and pop in the same cycle → both strobes 1; count stays 5; valid_out=1 the next cycle.
- Empty FIFO with pop=1 and push=1 → rdmem_enable=0, error=1, state ERROR. `init`=1 → INIT with error=0 and count=0.
- Assert `reset` with count=100 mid-stream → all outputs take reset values asynchronously; after release, the first push writes wr_addr=0.

Source files
------------

// File: rtl/fifo_mem_control_pkg.sv
// Shared definitions for the FIFO storage memory, its sequencing controller
// and their benches.
//   default_data_width    : memory word width
//   default_address_width : memory address width (depth = 2**address_width)
//   fifo_state_t          : controller FSM encodings (also visible on the
//                           controller's debug 'state' output)
package fifo_mem_control_pkg;

    localparam int default_data_width    = 10;
    localparam int default_address_width = 8;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } fifo_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter used for the FIFO write and read addresses.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, pointer -> 0
//   clr   : synchronous clear, has priority over en
//   en    : advance the pointer by one (wraps naturally at 2**width)
//   ptr   : registered pointer value
module fifo_ptr #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [width-1:0] ptr
);

    localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] ptr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else if (clr) begin
            ptr_reg <= '0;
        end else if (en) begin
            ptr_reg <= ptr_reg + one;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_mem_control.sv
// Sequencing controller for the dual-port FIFO storage memory. Converts
// push/pop requests into memory write/read strobes and addresses, tracks
// occupancy, decodes status flags and latches overflow/underflow as a
// sticky error. Data words do not pass through this block.
// Ports:
//   clk, reset          : clock and asynchronous active-low reset
//   init                : synchronous re-initialisation (also clears error)
//   push, pop           : requester write / read requests
//   thr_high, thr_low   : almost-full / almost-empty thresholds (taken in INIT)
//   wrmem_enable        : memory write strobe (combinational, = accepted push)
//   rdmem_enable        : memory read strobe (combinational, = accepted pop)
//   wr_addr, rd_addr    : registered memory addresses
//   valid_out           : read data valid, one cycle after an accepted pop
//   count               : occupancy 0..depth
//   empty, full, almost_empty, almost_full : decodes of count
//   error               : sticky overflow/underflow
//   state               : current FSM state (debug)
module fifo_mem_control
    import fifo_mem_control_pkg::*;
#(
    parameter int data_width    = default_data_width,
    parameter int address_width = default_address_width
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     push,
    input  logic                     pop,
    input  logic [address_width:0]   thr_high,
    input  logic [address_width:0]   thr_low,
    output logic                     wrmem_enable,
    output logic                     rdmem_enable,
    output logic [address_width-1:0] wr_addr,
    output logic [address_width-1:0] rd_addr,
    output logic                     valid_out,
    output logic [address_width:0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     error,
    output logic [1:0]               state
);

    // The word width only matters to the memory instance; reject a
    // nonsensical value at elaboration so mismatched hookups are caught.
    if (data_width < 1) begin : g_bad_data_width
        $error("fifo_mem_control: data_width must be at least 1");
    end

    localparam logic [address_width:0] depth     = {1'b1, {address_width{1'b0}}};
    localparam logic [address_width:0] count_one = {{address_width{1'b0}}, 1'b1};

    fifo_state_t              state_reg, state_next;
    logic [address_width:0]   count_reg, count_next;
    logic [address_width:0]   thr_low_reg, thr_high_reg;
    logic                     error_reg;
    logic                     valid_reg;

    logic accepting;
    logic push_ok, pop_ok;
    logic overflow, underflow;
    logic clear_all;

    // Requests are only honoured in IDLE/ACTIVE; INIT and ERROR ignore them.
    assign accepting = (state_reg == IDLE) || (state_reg == ACTIVE);
    assign push_ok   = accepting & push & ~full;
    assign pop_ok    = accepting & pop  & ~empty;
    // A pop in the same cycle does not rescue a push into a full FIFO, and a
    // push does not bypass into a pop from an empty one.
    assign overflow  = accepting & push & full;
    assign underflow = accepting & pop  & empty;

    // Pointers and count are cleared both on the edge that enters INIT and
    // while sitting in INIT, so INIT always presents an empty FIFO.
    assign clear_all = init | (state_reg == INIT);

    // ---------------------------------------------------------------
    // Write and read pointers
    // ---------------------------------------------------------------
    logic [1:0]               ptr_en;
    logic [address_width-1:0] ptr_val [2];

    assign ptr_en[0] = push_ok;
    assign ptr_en[1] = pop_ok;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
        fifo_ptr #(
            .width (address_width)
        ) u_ptr (
            .clk   (clk),
            .reset (reset),
            .clr   (clear_all),
            .en    (ptr_en[gi]),
            .ptr   (ptr_val[gi])
        );
    end

    assign wr_addr = ptr_val[0];
    assign rd_addr = ptr_val[1];

    // ---------------------------------------------------------------
    // Occupancy
    // ---------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + count_one;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - count_one;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear_all) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // ---------------------------------------------------------------
    // Thresholds: tracked only while in INIT, frozen elsewhere
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_low_reg  <= '0;
            thr_high_reg <= depth;
        end else if (state_reg == INIT) begin
            thr_low_reg  <= thr_low;
            thr_high_reg <= thr_high;
        end
    end

    // ---------------------------------------------------------------
    // Sticky error and read-valid
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_reg <= 1'b0;
        end else if (init) begin
            error_reg <= 1'b0;
        end else if (overflow || underflow) begin
            error_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= pop_ok;
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (init) begin
            state_next = INIT;
        end else begin
            case (state_reg)
                INIT: begin
                    state_next = IDLE;
                end
                IDLE: begin
                    if (overflow || underflow) begin
                        state_next = ERROR;
                    end else if (push_ok) begin
                        state_next = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (overflow || underflow) begin
                        state_next = ERROR;
                    end else if (count_next == '0) begin
                        state_next = IDLE;
                    end
                end
                ERROR: begin
                    state_next = ERROR;
                end
                default: begin
                    state_next = INIT;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign wrmem_enable = push_ok;
    assign rdmem_enable = pop_ok;
    assign valid_out    = valid_reg;
    assign count        = count_reg;
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == depth);
    assign almost_empty = (count_reg <= thr_low_reg);
    assign almost_full  = (count_reg >= thr_high_reg);
    assign error        = error_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_fifo_mem_control.sv
// Self-checking bench for fifo_mem_control: directed scenarios followed by a
// randomized run, all compared against a behavioural occupancy model.
module tb_fifo_mem_control;
    import fifo_mem_control_pkg::*;

    localparam int AW = default_address_width;
    localparam int DW = default_data_width;
    localparam int D  = 1 << AW;
    localparam int VW = 2 + 6 + (AW + 1) + AW + AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic          push;
    logic          pop;
    logic [AW:0]   thr_high;
    logic [AW:0]   thr_low;
    logic          wrmem_enable;
    logic          rdmem_enable;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          valid_out;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic          error;
    logic [1:0]    state;

    fifo_mem_control #(
        .data_width    (DW),
        .address_width (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .push         (push),
        .pop          (pop),
        .thr_high     (thr_high),
        .thr_low      (thr_low),
        .wrmem_enable (wrmem_enable),
        .rdmem_enable (rdmem_enable),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .valid_out    (valid_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .error        (error),
        .state        (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: state number, occupancy, addresses as plain integers
    int m_state;
    int m_count;
    int m_wr;
    int m_rd;
    int m_tl;
    int m_th;
    bit m_err;
    bit m_valid;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {state, error, valid_out, empty, full, almost_empty, almost_full,
                      count, wr_addr, rd_addr};

    function automatic logic [VW-1:0] exp_vec();
        logic [1:0]    s;
        logic [AW:0]   c;
        logic [AW-1:0] w;
        logic [AW-1:0] r;
        s = 2'(m_state);
        c = (AW + 1)'(m_count);
        w = AW'(m_wr);
        r = AW'(m_rd);
        return {s, m_err, m_valid, m_count == 0, m_count == D,
                m_count <= m_tl, m_count >= m_th, c, w, r};
    endfunction

    function automatic bit m_accepting();
        return (m_state == 1) || (m_state == 2);
    endfunction

    function automatic bit m_push_ok();
        return m_accepting() && push && (m_count < D);
    endfunction

    function automatic bit m_pop_ok();
        return m_accepting() && pop && (m_count > 0);
    endfunction

    task automatic model_reset();
        m_state = 0; m_count = 0; m_wr = 0; m_rd = 0;
        m_tl = 0; m_th = D; m_err = 1'b0; m_valid = 1'b0;
    endtask

    // One clock edge: the model consumes the same inputs the DUT samples.
    task automatic tick();
        bit pok, qok, bad;
        @(posedge clk);
        pok = m_push_ok();
        qok = m_pop_ok();
        bad = m_accepting() && ((push && m_count == D) || (pop && m_count == 0));
        if (m_state == 0) begin
            m_tl = int'(thr_low);
            m_th = int'(thr_high);
        end
        if (init) begin
            m_state = 0; m_count = 0; m_wr = 0; m_rd = 0; m_err = 1'b0;
        end else if (m_state == 0) begin
            m_count = 0; m_wr = 0; m_rd = 0; m_state = 1;
        end else if (m_accepting()) begin
            if (pok) begin m_wr = (m_wr + 1) % D; m_count++; end
            if (qok) begin m_rd = (m_rd + 1) % D; m_count--; end
            if (bad) begin
                m_err = 1'b1; m_state = 3;
            end else begin
                m_state = (m_count == 0) ? 1 : 2;
            end
        end
        m_valid = qok;
        #1;
    endtask

    task automatic drive(input bit p, input bit q, input bit i);
        push = p; pop = q; init = i;
        #1;
    endtask

    task automatic recover();
        drive(1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL recover_init: got %h required %h", dut_vec, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; init = 1'b1; push = 1'b0; pop = 1'b0;
        thr_low = (AW + 1)'(2); thr_high = (AW + 1)'(254);
        model_reset();
        #12;
        checks++;
        if (dut_vec !== exp_vec() || wrmem_enable !== 1'b0 || rdmem_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got %h/%b%b required %h/00", dut_vec,
                     wrmem_enable, rdmem_enable, exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 2'd0 || count !== '0 || empty !== 1'b1 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_init_hold: state=%0d count=%0d empty=%b ae=%b required 0 0 1 1",
                     state, count, empty, almost_empty);
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (state !== 2'd1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_to_idle: got %h required %h", dut_vec, exp_vec());
        end
        $display("txn reset: state=%0d count=%0d", state, count);
    endtask

    task automatic test_push3();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (wrmem_enable !== 1'b1 || wr_addr !== AW'(i)) begin
                failures++;
                $display("FAIL push3_strobe: wren=%b wr_addr=%0d required 1 %0d",
                         wrmem_enable, wr_addr, i);
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL push3_state: got %h required %h", dut_vec, exp_vec());
            end
            $display("txn push: wr_addr=%0d count=%0d ae=%b", i, count, almost_empty);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== (AW + 1)'(3) || almost_empty !== 1'b0 || state !== 2'd2) begin
            failures++;
            $display("FAIL push3_final: count=%0d ae=%b state=%0d required 3 0 2",
                     count, almost_empty, state);
        end
    endtask

    task automatic test_fill_overflow();
        while (m_count < D) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fill_step: got %h required %h", dut_vec, exp_vec());
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || almost_full !== 1'b1 || wr_addr !== '0 || count !== (AW + 1)'(D)) begin
            failures++;
            $display("FAIL fill_full: full=%b af=%b wr_addr=%0d count=%0d required 1 1 0 %0d",
                     full, almost_full, wr_addr, count, D);
        end
        $display("txn fill: count=%0d full=%b af=%b", count, full, almost_full);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (wrmem_enable !== 1'b0) begin
            failures++;
            $display("FAIL overflow_strobe: wren=%b required 0", wrmem_enable);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (error !== 1'b1 || state !== 2'd3 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL overflow_error: got %h required %h", dut_vec, exp_vec());
        end
        $display("txn overflow: error=%b state=%0d", error, state);
        recover();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (wrmem_enable !== 1'b1 || rdmem_enable !== 1'b1) begin
            failures++;
            $display("FAIL b2b_strobes: wren=%b rden=%b required 1 1", wrmem_enable, rdmem_enable);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== (AW + 1)'(5) || valid_out !== 1'b1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL b2b_after: count=%0d valid=%b vec=%h required 5 1 %h",
                     count, valid_out, dut_vec, exp_vec());
        end
        $display("txn push+pop: count=%0d valid_out=%b", count, valid_out);
        recover();
    endtask

    task automatic test_underflow();
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (rdmem_enable !== 1'b0) begin
            failures++;
            $display("FAIL underflow_strobe: rden=%b required 0", rdmem_enable);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (error !== 1'b1 || state !== 2'd3 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL underflow_error: got %h required %h", dut_vec, exp_vec());
        end
        $display("txn underflow: error=%b state=%0d", error, state);
        drive(1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (state !== 2'd0 || error !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL underflow_init: state=%0d error=%b count=%0d required 0 0 0",
                     state, error, count);
        end
        drive(1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (count !== (AW + 1)'(100)) begin
            failures++;
            $display("FAIL areset_pre: count=%0d required 100", count);
        end
        #2;
        push = 1'b1;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== exp_vec() || wrmem_enable !== 1'b0 || rdmem_enable !== 1'b0) begin
            failures++;
            $display("FAIL areset_values: got %h/%b%b required %h/00", dut_vec,
                     wrmem_enable, rdmem_enable, exp_vec());
        end
        $display("txn async_reset: count=%0d state=%0d", count, state);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (wrmem_enable !== 1'b1 || wr_addr !== '0) begin
            failures++;
            $display("FAIL areset_first_push: wren=%b wr_addr=%0d required 1 0", wrmem_enable, wr_addr);
        end
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL areset_after_push: got %h required %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        int push_pct;
        int pop_pct;
        for (int i = 0; i < 3000; i++) begin
            case ((i / 400) % 3)
                0:       begin push_pct = 90; pop_pct = 10; end
                1:       begin push_pct = 10; pop_pct = 90; end
                default: begin push_pct = 50; pop_pct = 50; end
            endcase
            if (m_state == 3 || $urandom_range(0, 299) == 0) begin
                thr_low  = (AW + 1)'($urandom_range(0, D));
                thr_high = (AW + 1)'($urandom_range(0, D));
                drive(1'b0, 1'b0, 1'b1);
                $display("txn random_init: cycle=%0d thr_low=%0d thr_high=%0d", i, thr_low, thr_high);
            end else begin
                drive($urandom_range(0, 99) < push_pct, $urandom_range(0, 99) < pop_pct, 1'b0);
            end
            checks++;
            if (wrmem_enable !== m_push_ok() || rdmem_enable !== m_pop_ok()) begin
                failures++;
                $display("FAIL random_strobes: cycle=%0d got %b%b required %b%b", i,
                         wrmem_enable, rdmem_enable, m_push_ok(), m_pop_ok());
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random_state: cycle=%0d got %h required %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_push3();
        test_fill_overflow();
        test_back_to_back();
        test_underflow();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
